// File: rtl/nios2_buttons_poller_if.sv
// Avalon-MM read bus to the button PIO plus the press/release event channel.
// Master modport is the poller's view; slave modport is the PIO/consumer side.
interface nios2_buttons_poller_if #(
    parameter int DATA_WIDTH = 4
);
    logic [1:0]            avm_address;
    logic                  avm_read;
    logic                  avm_waitrequest;
    logic [31:0]           avm_readdata;

    logic                  event_valid;
    logic                  event_ready;
    logic [DATA_WIDTH-1:0] event_press;
    logic [DATA_WIDTH-1:0] event_release;
    logic                  event_overrun;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        output event_valid,
        input  event_ready,
        output event_press,
        output event_release,
        output event_overrun
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        input  event_valid,
        output event_ready,
        input  event_press,
        input  event_release,
        input  event_overrun
    );
endinterface

// File: rtl/nios2_buttons_poller.sv
// Polls the button PIO over Avalon-MM, debounces the vector and emits press/release events.
// Latency: read every POLL_PERIOD+3 cycles; stable/event outputs update the cycle after capture.
// Backpressure: avm_waitrequest stalls REQ; an unaccepted event absorbs new ones by OR-merge and flags overrun.
module nios2_buttons_poller #(
    parameter int DATA_WIDTH       = 4,
    parameter int POLL_PERIOD      = 50000,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int READ_LATENCY     = 1,
    parameter bit ACTIVE_LOW       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    nios2_buttons_poller_if.master bus,
    output logic [DATA_WIDTH-1:0] buttons_stable
);
    localparam int TMR_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int RUN_W = $clog2(DEBOUNCE_SAMPLES + 1);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_PERIOD - 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(DEBOUNCE_SAMPLES);
    localparam logic [DATA_WIDTH-1:0] RELEASED = {DATA_WIDTH{ACTIVE_LOW}};

    typedef enum logic [1:0] {IDLE, REQ, WAIT, CAPT} state_t;

    state_t                state, state_nxt;
    logic [TMR_W-1:0]      timer, timer_nxt;
    logic [LAT_W-1:0]      lat_cnt, lat_nxt;
    logic                  capt;
    logic                  rd;

    logic [DATA_WIDTH-1:0] last_sample;
    logic [RUN_W-1:0]      run_cnt, run_upd;
    logic [DATA_WIDTH-1:0] sample, changed, new_press, new_release;
    logic                  new_evt;

    logic                  evt_vld;
    logic [DATA_WIDTH-1:0] evt_press, evt_release;
    logic                  evt_overrun;
    logic                  evt_take;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        lat_nxt   = lat_cnt;
        capt      = 1'b0;
        rd        = 1'b0;
        case (state)
            IDLE: begin
                if (timer == TMR_LAST) begin
                    state_nxt = REQ;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            REQ: begin
                rd = 1'b1;
                if (!bus.avm_waitrequest) begin
                    state_nxt = WAIT;
                    lat_nxt   = LAT_INIT;
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    state_nxt = CAPT;
                end else begin
                    lat_nxt = lat_cnt - LAT_W'(1);
                end
            end
            CAPT: begin
                capt      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Debounce: run counts consecutive identical captures, saturating at the threshold.
    always_comb begin
        sample  = bus.avm_readdata[DATA_WIDTH-1:0];
        run_upd = (sample != last_sample) ? RUN_W'(1)
                : (run_cnt >= RUN_MAX)    ? RUN_MAX
                :                           run_cnt + RUN_W'(1);
        new_evt = capt && (run_upd >= RUN_MAX) && (sample != buttons_stable);
        changed = sample ^ buttons_stable;
        if (ACTIVE_LOW) begin
            new_press   = changed & ~sample;
            new_release = changed & sample;
        end else begin
            new_press   = changed & sample;
            new_release = changed & ~sample;
        end
    end

    assign evt_take = evt_vld && bus.event_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            timer          <= '0;
            lat_cnt        <= '0;
            last_sample    <= RELEASED;
            run_cnt        <= '0;
            buttons_stable <= RELEASED;
            evt_vld        <= 1'b0;
            evt_press      <= '0;
            evt_release    <= '0;
            evt_overrun    <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            lat_cnt <= lat_nxt;
            if (capt) begin
                last_sample <= sample;
                run_cnt     <= run_upd;
            end
            if (new_evt) begin
                buttons_stable <= sample;
                if (!evt_vld || evt_take) begin
                    evt_press   <= new_press;
                    evt_release <= new_release;
                    evt_vld     <= 1'b1;
                end else begin
                    evt_press   <= evt_press | new_press;
                    evt_release <= evt_release | new_release;
                    evt_overrun <= 1'b1;
                end
            end else if (evt_take) begin
                evt_vld <= 1'b0;
            end
        end
    end

    assign bus.avm_address   = 2'b00;
    assign bus.avm_read      = rd;
    assign bus.event_valid   = evt_vld;
    assign bus.event_press   = evt_press;
    assign bus.event_release = evt_release;
    assign bus.event_overrun = evt_overrun;

    generate
        if (DATA_WIDTH < 32) begin : g_upper
            logic unused_readdata_hi;
            assign unused_readdata_hi = ^bus.avm_readdata[31:DATA_WIDTH];
        end
    endgenerate
endmodule
